// File: rtl/mem_access_ctrl.sv
// Memory-stage data-bus controller: req/addr_ok/data_ok handshake, pipeline stall,
// store lane encoding, load lane extraction with sign/zero extension, and bus timeout.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [1:0]  sizeM,
  input  logic        signM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        adelM,
  output logic        adesM,
  output logic        bus_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state;
  logic          mis;
  logic          acc;
  logic [1:0]    sizeL;
  logic          signL;
  logic [1:0]    offL;
  logic          wrL;
  logic [CW-1:0] toCnt;
  logic [3:0]    wstrbNext;
  logic [31:0]   wdataNext;
  logic [7:0]    lane;
  logic [15:0]   half;
  logic [31:0]   loadExt;
  logic          complete;
  logic          timedOut;

  always_comb begin
    mis = 1'b0;
    unique case (sizeM)
      2'b00:   mis = 1'b0;
      2'b01:   mis = addrM[0];
      default: mis = |addrM[1:0];
    endcase
  end

  assign acc    = (memreadM | memwriteM) & ~mis;
  assign adelM  = memreadM & mis;
  assign adesM  = memwriteM & mis;
  // Gated by rst so a pending access cannot hold the pipeline while in reset.
  assign stallM = rst & acc & (state != DONE);

  always_comb begin
    wstrbNext = 4'b1111;
    wdataNext = writedataM;
    unique case (sizeM)
      2'b00: begin
        wstrbNext = 4'b0001 << addrM[1:0];
        wdataNext = {4{writedataM[7:0]}};
      end
      2'b01: begin
        wstrbNext = addrM[1] ? 4'b1100 : 4'b0011;
        wdataNext = {2{writedataM[15:0]}};
      end
      default: begin
        wstrbNext = 4'b1111;
        wdataNext = writedataM;
      end
    endcase
  end

  always_comb begin
    lane = data_rdata[7:0];
    unique case (offL)
      2'd0: lane = data_rdata[7:0];
      2'd1: lane = data_rdata[15:8];
      2'd2: lane = data_rdata[23:16];
      2'd3: lane = data_rdata[31:24];
    endcase
    half    = offL[1] ? data_rdata[31:16] : data_rdata[15:0];
    loadExt = data_rdata;
    unique case (sizeL)
      2'b00:   loadExt = {{24{signL & lane[7]}}, lane};
      2'b01:   loadExt = {{16{signL & half[15]}}, half};
      default: loadExt = data_rdata;
    endcase
  end

  assign complete = ((state == REQ) && data_addr_ok && data_data_ok) ||
                    ((state == WAIT) && data_data_ok);
  assign timedOut = (TIMEOUT != 0) && ((toCnt + CW'(1)) == TO_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      toCnt      <= '0;
      readdataM  <= '0;
      bus_err    <= 1'b0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_addr  <= '0;
      data_wstrb <= '0;
      data_wdata <= '0;
      sizeL      <= '0;
      signL      <= 1'b0;
      offL       <= '0;
      wrL        <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          toCnt <= '0;
          if (acc) begin
            state      <= REQ;
            data_req   <= 1'b1;
            data_wr    <= memwriteM;
            data_addr  <= {addrM[31:2], 2'b00};
            data_wstrb <= memwriteM ? wstrbNext : '0;
            data_wdata <= memwriteM ? wdataNext : '0;
            sizeL      <= sizeM;
            signL      <= signM;
            offL       <= addrM[1:0];
            wrL        <= memwriteM;
          end
        end
        REQ, WAIT: begin
          toCnt <= (toCnt == TO_LIMIT) ? toCnt : toCnt + CW'(1);
          // Completion on the same edge as the timeout wins; no error is flagged then.
          if (complete) begin
            state    <= DONE;
            data_req <= 1'b0;
            if (!wrL) readdataM <= loadExt;
          end else if (timedOut) begin
            state    <= DONE;
            data_req <= 1'b0;
            bus_err  <= 1'b1;
          end else if ((state == REQ) && data_addr_ok) begin
            state    <= WAIT;
            data_req <= 1'b0;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, misalignment, timeout and async reset.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreadM, memwriteM, signM;
  logic [1:0]  sizeM;
  logic [31:0] addrM, writedataM;
  logic [31:0] readdataM;
  logic        stallM, adelM, adesM, bus_err;
  logic        data_req, data_wr;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .memreadM(memreadM), .memwriteM(memwriteM), .sizeM(sizeM), .signM(signM),
    .addrM(addrM), .writedataM(writedataM), .readdataM(readdataM),
    .stallM(stallM), .adelM(adelM), .adesM(adesM), .bus_err(bus_err),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is IDLE, cycle 1 the first REQ cycle. addr_ok arrives at cycle 1+aok,
  // data_ok dok cycles after it (dok < 0: never). Returns with the DONE cycle in progress.
  task automatic doAccess(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rdat,
                          input int aok, input int dok,
                          output int stalls, output logic [31:0] reqAddr, output logic [3:0] reqStrb,
                          output logic [31:0] reqWdata, output logic reqWr, output logic reqSeen,
                          output logic sawErr);
    memreadM = rd; memwriteM = wr; sizeM = sz; signM = sg; addrM = ad; writedataM = wd;
    data_rdata = rdat;
    stalls = 0; sawErr = 1'b0; reqSeen = 1'b0;
    reqAddr = '0; reqStrb = '0; reqWdata = '0; reqWr = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      data_addr_ok = (cyc == 1 + aok);
      data_data_ok = (dok >= 0) && (cyc == 1 + aok + dok);
      #1;
      if (cyc == 1) begin
        reqSeen = data_req; reqAddr = data_addr; reqStrb = data_wstrb;
        reqWdata = data_wdata; reqWr = data_wr;
      end
      if (bus_err) sawErr = 1'b1;
      if (!stallM) break;
      stalls++;
      step();
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
  endtask

  task automatic finishAccess();
    memreadM = 1'b0; memwriteM = 1'b0;
    step();
  endtask

  int          stalls;
  logic [31:0] rAddr, rWdata, prevRd;
  logic [3:0]  rStrb;
  logic        rWr, rSeen, sawErr, anyReq;

  initial begin
    rst = 1'b0;
    memreadM = 1'b1; memwriteM = 1'b0; sizeM = 2'b10; signM = 1'b0;
    addrM = 32'h100; writedataM = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    step(); step();
    checkVal("rst_stall", stallM, 0);
    checkVal("rst_req", data_req, 0);
    checkVal("rst_rdata", readdataM, 0);
    checkVal("rst_addr", data_addr, 0);
    checkVal("rst_wstrb", data_wstrb, 0);
    checkVal("rst_wdata", data_wdata, 0);
    checkVal("rst_buserr", bus_err, 0);
    memreadM = 1'b0;
    rst = 1'b1;
    step();

    // LW 0x100: addr_ok in first REQ cycle, data_ok two cycles later
    doAccess(1, 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 0, 2, stalls, rAddr, rStrb, rWdata, rWr, rSeen, sawErr);
    checkVal("lw_req", rSeen, 1);
    checkVal("lw_addr", rAddr, 32'h100);
    checkVal("lw_wstrb", rStrb, 0);
    checkVal("lw_wr", rWr, 0);
    checkVal("lw_stalls", stalls, 4);
    checkVal("lw_data", readdataM, 32'hDEADBEEF);
    checkVal("lw_done_req", data_req, 0);
    finishAccess();

    // LB / LBU lane 3, same-cycle handshake
    doAccess(1, 0, 2'b00, 1, 32'h103, 0, 32'h80112233, 0, 0, stalls, rAddr, rStrb, rWdata, rWr, rSeen, sawErr);
    checkVal("lb_stalls", stalls, 2);
    checkVal("lb_addr", rAddr, 32'h100);
    checkVal("lb_data", readdataM, 32'hFFFFFF80);
    finishAccess();
    doAccess(1, 0, 2'b00, 0, 32'h103, 0, 32'h80112233, 0, 0, stalls, rAddr, rStrb, rWdata, rWr, rSeen, sawErr);
    checkVal("lbu_data", readdataM, 32'h00000080);
    finishAccess();
    doAccess(1, 0, 2'b00, 1, 32'h101, 0, 32'h80112233, 0, 0, stalls, rAddr, rStrb, rWdata, rWr, rSeen, sawErr);
    checkVal("lb1_data", readdataM, 32'h00000022);
    finishAccess();
    doAccess(1, 0, 2'b01, 1, 32'h102, 0, 32'h80112233, 1, 1, stalls, rAddr, rStrb, rWdata, rWr, rSeen, sawErr);
    checkVal("lh_stalls", stalls, 4);
    checkVal("lh_data", readdataM, 32'hFFFF8011);
    finishAccess();
    doAccess(1, 0, 2'b01, 0, 32'h100, 0, 32'h8011A233, 0, 0, stalls, rAddr, rStrb, rWdata, rWr, rSeen, sawErr);
    checkVal("lhu_data", readdataM, 32'h0000A233);
    finishAccess();

    // Stores: lane encoding, readdataM untouched
    prevRd = 32'h0000A233;
    doAccess(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h55555555, 0, 0, stalls, rAddr, rStrb, rWdata, rWr, rSeen, sawErr);
    checkVal("sh_addr", rAddr, 32'h200);
    checkVal("sh_wstrb", rStrb, 4'b1100);
    checkVal("sh_wdata", rWdata, 32'hABCDABCD);
    checkVal("sh_wr", rWr, 1);
    checkVal("sh_rdata_keep", readdataM, prevRd);
    finishAccess();
    doAccess(0, 1, 2'b00, 0, 32'h301, 32'h12345678, 0, 0, 0, stalls, rAddr, rStrb, rWdata, rWr, rSeen, sawErr);
    checkVal("sb_wstrb", rStrb, 4'b0010);
    checkVal("sb_wdata", rWdata, 32'h78787878);
    finishAccess();
    doAccess(0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 0, 0, 0, stalls, rAddr, rStrb, rWdata, rWr, rSeen, sawErr);
    checkVal("sw_wstrb", rStrb, 4'b1111);
    checkVal("sw_wdata", rWdata, 32'hCAFEF00D);
    finishAccess();

    // Misaligned accesses: flag only, no stall, no request
    memreadM = 1'b1; sizeM = 2'b10; addrM = 32'h102; anyReq = 1'b0;
    #1;
    checkVal("adel_lw", adelM, 1);
    checkVal("adel_stall", stallM, 0);
    for (int i = 0; i < 3; i++) begin step(); anyReq |= data_req; end
    checkVal("adel_noreq", anyReq, 0);
    memreadM = 1'b0; memwriteM = 1'b1; addrM = 32'h101;
    #1;
    checkVal("ades_sw", adesM, 1);
    checkVal("ades_adel", adelM, 0);
    sizeM = 2'b01; addrM = 32'h203;
    #1;
    checkVal("ades_sh", adesM, 1);
    sizeM = 2'b11; memwriteM = 1'b0; memreadM = 1'b1; addrM = 32'h102;
    #1;
    checkVal("adel_rsv", adelM, 1);
    memreadM = 1'b0;
    step();

    // Timeout: addr_ok, never data_ok
    doAccess(1, 0, 2'b10, 0, 32'h500, 0, 32'h11111111, 0, -1, stalls, rAddr, rStrb, rWdata, rWr, rSeen, sawErr);
    checkVal("to_stalls", stalls, 5);
    checkVal("to_buserr", bus_err, 1);
    checkVal("to_rdata_keep", readdataM, prevRd);
    finishAccess();
    checkVal("to_pulse", bus_err, 0);
    doAccess(1, 0, 2'b10, 0, 32'h504, 0, 32'h13572468, 0, 0, stalls, rAddr, rStrb, rWdata, rWr, rSeen, sawErr);
    checkVal("to_recover", readdataM, 32'h13572468);
    finishAccess();

    // Async reset while in WAIT
    memreadM = 1'b1; sizeM = 2'b10; addrM = 32'h600; data_rdata = 32'h2468ACE0;
    step();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkVal("mrst_rdata", readdataM, 0);
    checkVal("mrst_stall", stallM, 0);
    checkVal("mrst_addr", data_addr, 0);
    memreadM = 1'b0;
    step();
    rst = 1'b1;
    data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    step();
    checkVal("late_ok_rdata", readdataM, 0);
    checkVal("late_ok_req", data_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
